// File: rtl/tlul_sram_pkg.sv
// tlul_sram_pkg: shared opcodes, response entry type and lane-mask helper for the TL-UL SRAM adapter
package tlul_sram_pkg;
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] D_ACK         = 3'd0;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    // Byte lanes covered by an access of 2**size bytes starting at addr_lo.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        return size == 2'd0 ? 4'b0001 << addr_lo : size == 2'd1 ? 4'b0011 << addr_lo : 4'b1111;
    endfunction
endpackage

// File: rtl/tlul_sram_adapter_if.sv
// tlul_sram_adapter_if: TL-UL A/D channel bundle; master = host side, slave = device side
interface tlul_sram_adapter_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );
    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );
endinterface

// File: rtl/tlul_rsp_fifo.sv
// tlul_rsp_fifo: synchronous FIFO of response entries
//   push_i/wdata_i enqueue, pop_i dequeues, rdata_o is the head,
//   count_o/empty_o/full_o report occupancy; pushes when full and pops when empty are ignored
module tlul_rsp_fifo
    import tlul_sram_pkg::*;
#(
    parameter int Depth = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  rsp_t                         wdata_i,
    input  logic                         pop_i,
    output rsp_t                         rdata_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    rsp_t          mem_q [Depth];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(Depth);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d    = do_push ? (wr_q == PW'(Depth - 1) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d    = do_pop ? (rd_q == PW'(Depth - 1) ? '0 : rd_q + PW'(1)) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/tlul_sram_adapter.sv
// tlul_sram_adapter: TL-UL device adapter in front of a 1-cycle registered-read word SRAM
//   clk_i/rst_ni: clock shared with the SRAM, async active-low reset
//   tl: A-channel requests in, D-channel responses out (slave side)
//   mem_*: SRAM chip enable, byte write mask, write data, word address, read data (valid one cycle after enable)
module tlul_sram_adapter
    import tlul_sram_pkg::*;
#(
    parameter int AddrWidth = 12,
    parameter int RspDepth  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tlul_sram_adapter_if.slave   tl,
    output logic                 mem_en_o,
    output logic [3:0]           mem_we_o,
    output logic [31:0]          mem_wdata_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic [31:0]          mem_rdata_i
);
    logic [3:0]                    lanes;
    logic                          misaligned, req_err, accept, pop;
    logic                          pending_q;
    rsp_t                          req_q, push_rsp, head;
    logic [$clog2(RspDepth+1)-1:0] fifo_count;
    logic                          fifo_empty, fifo_full;
    logic                          unused_sig;

    assign lanes      = lane_mask(tl.a_size, tl.a_address[1:0]);
    assign misaligned = (tl.a_size == 2'd1 && tl.a_address[0]) || (tl.a_size == 2'd2 && |tl.a_address[1:0]);
    assign req_err    = !(tl.a_opcode inside {A_PUT_FULL, A_PUT_PARTIAL, A_GET}) || tl.a_size == 2'd3 || misaligned
                        || (tl.a_opcode == A_PUT_FULL && tl.a_mask != lanes) || |(tl.a_mask & ~lanes);

    // Credits count both queued responses and the read still in the SRAM, so the FIFO can never overflow.
    assign tl.a_ready = int'(fifo_count) + int'(pending_q) < RspDepth;
    assign accept     = tl.a_valid && tl.a_ready;

    assign mem_en_o    = accept && !req_err;
    assign mem_we_o    = mem_en_o && tl.a_opcode != A_GET ? tl.a_mask : 4'h0;
    assign mem_wdata_o = tl.a_data;
    assign mem_addr_o  = tl.a_address[AddrWidth+1:2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            req_q     <= '0;
        end else begin
            pending_q <= accept;
            if (accept) req_q <= '{opcode: tl.a_opcode == A_GET ? D_ACK_DATA : D_ACK, size: tl.a_size,
                                   source: tl.a_source, data: 32'h0, error: req_err};
        end
    end

    // Only a successful Get carries SRAM data; everything else answers with zero.
    always_comb begin
        push_rsp      = req_q;
        push_rsp.data = req_q.opcode == D_ACK_DATA && !req_q.error ? mem_rdata_i : 32'h0;
    end

    tlul_rsp_fifo #(.Depth(RspDepth)) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pending_q),
        .wdata_i (push_rsp),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign pop         = tl.d_valid && tl.d_ready;
    assign tl.d_valid  = !fifo_empty;
    assign tl.d_opcode = head.opcode;
    assign tl.d_size   = head.size;
    assign tl.d_source = head.source;
    assign tl.d_data   = head.data;
    assign tl.d_error  = head.error;

    assign unused_sig = ^{tl.a_address[31:AddrWidth+2], fifo_full};
endmodule

// File: tb/tb_tlul_sram_adapter.sv
// tb_tlul_sram_adapter: scoreboard bench for tlul_sram_adapter with a byte-lane reference memory
module tb_tlul_sram_adapter;
    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_rdata_i;

    exp_t        exp_q[$];
    int          pop_log[$];
    int          acc_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          d_mode = 1;
    logic [31:0] sram [4096];
    logic [31:0] ref_mem [4096];

    tlul_sram_adapter_if tl();

    tlul_sram_adapter #(.AddrWidth(12), .RspDepth(3)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tl          (tl),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        if (mem_en_o) begin
            logic [31:0] bm;
            bm = {{8{mem_we_o[3]}}, {8{mem_we_o[2]}}, {8{mem_we_o[1]}}, {8{mem_we_o[0]}}};
            if (mem_we_o == 4'h0) mem_rdata_i <= sram[mem_addr_o];
            else sram[mem_addr_o] <= (sram[mem_addr_o] & ~bm) | (mem_wdata_o & bm);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [2:0] op, input logic [1:0] size,
                                       input logic [31:0] addr, input logic [3:0] mask);
        int bytes, lanes;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4) || size > 2'd2) return 1'b1;
        bytes = 1 << size;
        if (addr % bytes != 0) return 1'b1;
        lanes = ((1 << bytes) - 1) << (addr % 4);
        if ((int'(mask) & ~lanes) != 0) return 1'b1;
        return op == 3'd0 && int'(mask) != lanes;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        tl.a_valid   = 1'b1;
        tl.a_opcode  = op;
        tl.a_size    = size;
        tl.a_source  = src;
        tl.a_address = addr;
        tl.a_mask    = mask;
        tl.a_data    = data;
    endtask

    task automatic predict();
        logic [2:0]  op;
        logic [3:0]  mask;
        logic [31:0] addr, data;
        logic        err;
        int          w;
        exp_t        e;
        op   = tl.a_opcode;
        mask = tl.a_mask;
        addr = tl.a_address;
        data = tl.a_data;
        err  = model_err(op, tl.a_size, addr, mask);
        w    = int'(addr[13:2]);
        chk("mem_drive", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o},
            {!err, (err || op == 3'd4) ? 4'h0 : mask, addr[13:2], data});
        e.op   = op == 3'd4 ? 3'd1 : 3'd0;
        e.size = tl.a_size;
        e.src  = tl.a_source;
        e.err  = err;
        e.data = (!err && op == 3'd4) ? ref_mem[w] : 32'h0;
        e.cyc  = cyc;
        exp_q.push_back(e);
        acc_log.push_back(cyc);
        if (!err && op != 3'd4)
            for (int b = 0; b < 4; b++) if (mask[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        int w = 0;
        drive(op, size, src, addr, mask, data);
        #1;
        while (!tl.a_ready && w < 200) begin
            @(negedge clk_i);
            #1;
            w++;
        end
        chk("a_accept_wait", tl.a_ready, 1);
        if (tl.a_ready) predict();
        @(negedge clk_i);
    endtask

    task automatic idle();
        tl.a_valid = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic drain();
        int w = 0;
        d_mode = 1;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk_i);
            w++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic stall_fill(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            drive(3'd4, 2'd2, 8'(8'h20 + i), 32'(4 * i), 4'hF, 32'h0);
            #1;
            if (tl.a_ready) begin
                predict();
                n++;
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        tl.d_ready = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            tl.d_ready = d_mode == 2 ? 1'($urandom_range(0, 1)) : d_mode == 1;
        end
    end

    // Monitor: every presented response is compared against the queue head, every cycle it is shown.
    initial forever begin
        @(negedge clk_i);
        #2;
        if (rst_ni && tl.d_valid) begin
            if (exp_q.size() == 0) chk("d_unexpected", tl.d_valid, 0);
            else begin
                chk("d_rsp", {tl.d_opcode, tl.d_size, tl.d_source, tl.d_data, tl.d_error},
                    {exp_q[0].op, exp_q[0].size, exp_q[0].src, exp_q[0].data, exp_q[0].err});
                if (tl.d_ready) begin
                    chk("d_latency", 64'(cyc >= exp_q[0].cyc + 2), 1);
                    pop_log.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        tl.a_valid = 1'b0;
        tl.a_opcode = 3'd0;
        tl.a_size = 2'd0;
        tl.a_source = 8'd0;
        tl.a_address = 32'd0;
        tl.a_mask = 4'd0;
        tl.a_data = 32'd0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_d_valid", tl.d_valid, 0);
        chk("rst_a_ready", tl.a_ready, 1);
        chk("rst_mem_en", mem_en_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 16; i++) issue(3'd0, 2'd2, 8'(i), 32'(4 * i), 4'hF, $urandom);

        issue(3'd0, 2'd2, 8'd1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(3'd4, 2'd2, 8'd2, 32'h10, 4'hF, 32'h0);
        issue(3'd0, 2'd2, 8'd3, 32'h10, 4'hF, 32'h11223344);
        issue(3'd1, 2'd1, 8'd4, 32'h12, 4'b1100, 32'hAABB0000);
        issue(3'd4, 2'd2, 8'd5, 32'h10, 4'hF, 32'h0);
        issue(3'd4, 2'd2, 8'd8, 32'h03, 4'hF, 32'h0);
        issue(3'd3, 2'd2, 8'd9, 32'h00, 4'hF, 32'h0);
        idle();
        drain();

        acc_log.delete();
        pop_log.delete();
        issue(3'd4, 2'd2, 8'd5, 32'h0, 4'hF, 32'h0);
        issue(3'd4, 2'd2, 8'd6, 32'h4, 4'hF, 32'h0);
        issue(3'd4, 2'd2, 8'd7, 32'h8, 4'hF, 32'h0);
        idle();
        drain();
        chk("b2b_pops", pop_log.size(), 3);
        if (pop_log.size() == 3 && acc_log.size() == 3)
            for (int i = 0; i < 3; i++) begin
                chk("b2b_accept_cycle", acc_log[i], acc_log[0] + i);
                chk("b2b_resp_cycle", pop_log[i], acc_log[0] + 2 + i);
            end

        d_mode = 0;
        stall_fill(8, n);
        #1;
        chk("stall_accepts", n, 3);
        chk("stall_a_ready", tl.a_ready, 0);
        tl.a_valid = 1'b0;
        repeat (4) @(negedge clk_i);
        drain();

        d_mode = 0;
        stall_fill(5, n);
        tl.a_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        #3;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_d_valid", tl.d_valid, 0);
        chk("midrst_a_ready", tl.a_ready, 1);
        chk("midrst_mem_en", mem_en_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        d_mode = 1;
        @(negedge clk_i);

        d_mode = 2;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            op = r < 3 ? 3'd0 : r < 5 ? 3'd1 : r < 9 ? 3'd4 : 3'($urandom);
            size = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            addr = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << size) - 1);
            mask = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'(((1 << (1 << size)) - 1) << (addr % 4));
            if (op == 3'd1 && $urandom_range(0, 1) == 1) mask = mask & 4'($urandom);
            issue(op, size, 8'(i), addr, mask, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
